// File: rtl/sum_stream_fifo_if.sv
// Stream bundle between the summing-block consumer FIFO and its neighbours.
interface sum_stream_fifo_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = 8
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] din;
  logic                  din_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_vld;
  logic                  dout_rd;
  logic [LVL_W-1:0]      level;
  logic                  warm;
  logic                  overflow;
  logic [CNT_WIDTH-1:0]  drop_cnt;

  // Producer/consumer side driving the FIFO
  modport master (
    output din, din_en, dout_rd,
    input  dout, dout_vld, level, warm, overflow, drop_cnt
  );

  // FIFO side
  modport slave (
    input  din, din_en, dout_rd,
    output dout, dout_vld, level, warm, overflow, drop_cnt
  );
endinterface

// File: rtl/sum_stream_fifo.sv
// First-word-fall-through FIFO capturing the upstream sum, with warm-up
// discard of pipeline refill samples and sticky overflow / saturating drop count.
module sum_stream_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned WARMUP     = 2,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input logic               clk,
  input logic               rst_n,
  sum_stream_fifo_if.slave  bus
);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned WCNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  dout_vld_q, dout_vld_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic                  warm_q, warm_d;
  logic                  overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;

  logic push_req;
  logic pop;
  logic full;
  logic push;
  logic drop;

  // Next-state: warm-up counting, push/pop arbitration, drop accounting
  always_comb begin
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    wcnt_d     = wcnt_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    push_req = bus.din_en && warm_q;
    pop      = dout_vld_q && bus.dout_rd;
    full     = (level_q == LVL_W'(DEPTH));
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;

    if (wcnt_q != WCNT_W'(WARMUP)) begin
      wcnt_d = wcnt_q + WCNT_W'(1);
    end

    if (push) begin
      mem_d[wptr_q] = bus.din;
      wptr_d        = wptr_q + PTR_W'(1);
    end

    if (pop) begin
      rptr_d = rptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != {CNT_WIDTH{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
      end
    end

    dout_vld_d = (level_d != '0);
    warm_d     = (wcnt_d == WCNT_W'(WARMUP));
  end

  // State registers; reset discards buffered data and restarts warm-up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      dout_vld_q <= 1'b0;
      wcnt_q     <= '0;
      warm_q     <= (WARMUP == 0);
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      dout_vld_q <= dout_vld_d;
      wcnt_q     <= wcnt_d;
      warm_q     <= warm_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Head of FIFO falls through from storage; stale when empty
  assign bus.dout     = mem_q[rptr_q];
  assign bus.dout_vld = dout_vld_q;
  assign bus.level    = level_q;
  assign bus.warm     = warm_q;
  assign bus.overflow = overflow_q;
  assign bus.drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_sum_stream_fifo.sv
// Bench for sum_stream_fifo: directed scenarios plus random traffic, all
// compared against a queue-based reference model.
module tb_sum_stream_fifo;
  localparam int unsigned DW     = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned WARMUP = 2;
  localparam int unsigned CNT_W  = 2;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;

  int n_tests;
  int n_fail;

  // Reference model state
  logic [DW-1:0] mq[$];
  int            m_wcnt;
  bit            m_ovf;
  int            m_drop;

  sum_stream_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CNT_W)) bus ();

  sum_stream_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .WARMUP    (WARMUP),
    .CNT_WIDTH (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_wcnt = 0;
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  task automatic model_step(input logic [DW-1:0] d, input logic en, input logic rd);
    bit preq;
    bit mpop;
    int sz;
    preq = en && (m_wcnt == int'(WARMUP));
    mpop = (mq.size() != 0) && rd;
    sz   = mq.size();
    if (mpop) void'(mq.pop_front());
    if (preq) begin
      if (sz < int'(DEPTH) || mpop) mq.push_back(d);
      else begin
        m_ovf = 1'b1;
        if (m_drop < CNT_MAX) m_drop++;
      end
    end
    if (m_wcnt < int'(WARMUP)) m_wcnt++;
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, "_vld"},  int'(bus.dout_vld), int'(mq.size() != 0));
    chk({pfx, "_lvl"},  int'(bus.level),    mq.size());
    chk({pfx, "_warm"}, int'(bus.warm),     int'(m_wcnt == int'(WARMUP)));
    chk({pfx, "_ovf"},  int'(bus.overflow), int'(m_ovf));
    chk({pfx, "_drop"}, int'(bus.drop_cnt), m_drop);
    if (mq.size() != 0) chk({pfx, "_dout"}, int'(bus.dout), int'(mq[0]));
  endtask

  // Called in the low clock phase; returns at the following negedge
  task automatic step(input logic [DW-1:0] d, input logic en, input logic rd);
    bus.din    = d;
    bus.din_en = en;
    bus.dout_rd = rd;
    @(posedge clk);
    model_step(d, en, rd);
    #1;
    check_outputs("step");
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_vld"},  int'(bus.dout_vld), 0);
    chk({pfx, "_lvl"},  int'(bus.level),    0);
    chk({pfx, "_warm"}, int'(bus.warm),     0);
    chk({pfx, "_ovf"},  int'(bus.overflow), 0);
    chk({pfx, "_drop"}, int'(bus.drop_cnt), 0);
    chk({pfx, "_dout"}, int'(bus.dout),     0);
  endtask

  // Called at a negedge; asserts reset between edges and releases at a later negedge
  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1 check_reset_values("rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic warm_up();
    for (int i = 0; i < int'(WARMUP); i++) step(8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    int exp_sat[5];
    n_tests = 0;
    n_fail  = 0;
    bus.din = '0;
    bus.din_en = 1'b0;
    bus.dout_rd = 1'b0;
    rst_n = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_values("init");
    @(negedge clk);
    rst_n = 1'b1;

    // Warm-up discards first two samples
    step(8'h11, 1'b1, 1'b0);
    step(8'h22, 1'b1, 1'b0);
    step(8'h33, 1'b1, 1'b0);
    step(8'h44, 1'b1, 1'b0);
    chk("warm_lvl",  int'(bus.level),    2);
    chk("warm_head", int'(bus.dout),     8'h33);
    chk("warm_drop", int'(bus.drop_cnt), 0);
    step(8'h00, 1'b0, 1'b1);
    chk("warm_next", int'(bus.dout), 8'h44);
    step(8'h00, 1'b0, 1'b1);

    // Fill past capacity, then drain
    for (int k = 1; k <= 6; k++) step(DW'(k), 1'b1, 1'b0);
    chk("fill_lvl",  int'(bus.level),    4);
    chk("fill_drop", int'(bus.drop_cnt), 2);
    chk("fill_ovf",  int'(bus.overflow), 1);
    for (int k = 1; k <= 4; k++) begin
      chk("fill_order", int'(bus.dout), k);
      step(8'h00, 1'b0, 1'b1);
    end
    chk("fill_ovf_sticky", int'(bus.overflow), 1);

    // Full FIFO with simultaneous push and pop
    do_reset();
    warm_up();
    for (int k = 0; k < 4; k++) step(8'hA0 + DW'(k), 1'b1, 1'b0);
    step(8'hA4, 1'b1, 1'b1);
    chk("fullpp_dout", int'(bus.dout),     8'hA1);
    chk("fullpp_lvl",  int'(bus.level),    4);
    chk("fullpp_drop", int'(bus.drop_cnt), 0);
    for (int k = 1; k <= 4; k++) begin
      chk("fullpp_order", int'(bus.dout), 8'hA0 + k);
      step(8'h00, 1'b0, 1'b1);
    end

    // Pointer wrap with single push/pop pairs
    for (int k = 0; k < 10; k++) begin
      step(DW'(k), 1'b1, 1'b1);
      chk("wrap_dout", int'(bus.dout), k);
      chk("wrap_lvl_le1", int'(bus.level <= 1), 1);
    end
    step(8'h00, 1'b0, 1'b1);

    // Drop counter saturation
    do_reset();
    warm_up();
    for (int k = 0; k < 4; k++) step(DW'(k), 1'b1, 1'b0);
    exp_sat = '{1, 2, 3, 3, 3};
    for (int i = 0; i < 5; i++) begin
      step(8'hEE, 1'b1, 1'b0);
      chk("sat_drop", int'(bus.drop_cnt), exp_sat[i]);
    end

    // Reset mid-stream with level=3 and overflow=1
    do_reset();
    warm_up();
    for (int k = 0; k < 5; k++) step(8'h60 + DW'(k), 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b1);
    chk("mid_lvl_pre", int'(bus.level),    3);
    chk("mid_ovf_pre", int'(bus.overflow), 1);
    do_reset();
    step(8'h55, 1'b1, 1'b0);
    chk("mid_warm0", int'(bus.warm), 0);
    step(8'h56, 1'b1, 1'b0);
    chk("mid_warm1", int'(bus.warm), 1);
    chk("mid_lvl_ign", int'(bus.level), 0);
    step(8'h57, 1'b1, 1'b0);
    chk("mid_first", int'(bus.dout), 8'h57);

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      step(DW'($urandom), ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sum_stream_fifo.md
# sum_stream_fifo

Downstream consumer of the two-stage register-pair summing block: captures its 8-bit sum output `o` into a small first-word-fall-through FIFO and presents it on a valid/ready stream. It discards the warm-up samples produced while the upstream register pipeline refills after reset. It also tracks overflow with a sticky flag and a saturating drop counter.

## Interface
- `DATA_WIDTH`, 8: width of captured sum and of `dout`.
- `DEPTH`, 4: FIFO entries. Power of two, at least 2.
- `WARMUP`, 2: number of cycles after reset release during which `din` is ignored. Matches the upstream register latency. 0 disables warm-up.
- `CNT_WIDTH`, 8: width of `drop_cnt`.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `din`, in, DATA_WIDTH: sum from the upstream block (`o`).
- `din_en`, in, 1: capture request for `din` this cycle.
- `dout`, out, DATA_WIDTH: FIFO head entry.
- `dout_vld`, out, 1: FIFO non-empty.
- `dout_rd`, in, 1: consumer ready. A pop occurs when `dout_vld && dout_rd`.
- `level`, out, clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `warm`, out, 1: warm-up complete; capture is allowed.
- `overflow`, out, 1: sticky; set on the first dropped sample.
- `drop_cnt`, out, CNT_WIDTH: number of dropped samples, saturating.

## Operation
- Warm-up counter:
  - Cleared by reset.
  - Increments each cycle while below WARMUP.
  - `warm` = (counter == WARMUP).
  - While `warm`=0, `din_en` is ignored. This is not a drop; `drop_cnt` and `overflow` are unaffected.
- Push request: `push_req = din_en && warm`.
- Pop: `pop = dout_vld && dout_rd`.
- Push is accepted when `push_req && (level < DEPTH || pop)`.
  - A full FIFO with a simultaneous pop accepts the push; `level` stays DEPTH.
- Drop occurs when `push_req && level == DEPTH && !pop`.
  - `overflow` <= 1.
  - `drop_cnt` <= min(`drop_cnt`+1, 2^CNT_WIDTH-1).
- Storage:
  - Circular buffer with write and read pointers of clog2(DEPTH) bits, wrapping modulo DEPTH.
  - `level` updates by +1 for push only, -1 for pop only, and is unchanged for both or neither.
- `dout` = entry at the read pointer, combinational from storage.
  - When empty, `dout` shows the stale entry; consumers must qualify it with `dout_vld`.
- Pop on empty is impossible by construction, since `dout_vld`=0.
- Push and pop in the same cycle on an empty FIFO: no pop; push accepted.
- Reset values:
  - `dout_vld`=0, `level`=0, `warm`=0 (1 if WARMUP=0), `overflow`=0, `drop_cnt`=0.
  - All storage entries = 0, so `dout`=0.
  - Pointers = 0.
- Reset asserted mid-operation clears all state immediately and restarts warm-up. Buffered data is lost.

## Timing
- Capture latency: a sample accepted at edge N appears on `dout` with `dout_vld`=1 after edge N, in cycle N+1, if the FIFO was empty. Otherwise it appears behind earlier entries.
- Pop at edge N: the next entry, or `dout_vld`=0, is visible after edge N.
- `warm` rises after edge WARMUP following reset release. The first accepted capture is at edge WARMUP+1.
  - Example with WARMUP=2: edges 1 and 2 are ignored; the `din` sampled at edge 3 is the first accepted.
- `overflow` and `drop_cnt` update at the edge on which the drop occurs.
- No combinational path from `dout_rd` to `dout_vld` or `dout`; from `din`/`din_en` to any output; or to `level`.

## Test plan
- **Warm-up:** reset, then `din_en`=1 with `din`=0x11, 0x22, 0x33, 0x44 on consecutive edges, `dout_rd`=0, WARMUP=2. Required: FIFO holds 0x33, 0x44; `level`=2; `drop_cnt`=0.
- **Fill and overflow:** after warm-up, push 0x01..0x06 with `dout_rd`=0, DEPTH=4. Required:
  - `level`=4.
  - Drain order 0x01, 0x02, 0x03, 0x04.
  - `drop_cnt`=2, `overflow`=1.
  - `overflow` stays 1 after the drain.
- **Full with simultaneous push and pop:** FIFO full with 0xA0..0xA3; push 0xA4 with `dout_rd`=1. Required:
  - `dout`=0xA1 next cycle, `level`=4, no drop.
  - Later drain order 0xA1, 0xA2, 0xA3, 0xA4.
- **Pointer wrap:** 10 single push/pop pairs with `din`=k (k=0..9) and `dout_rd` held 1. Required: each k appears on `dout` one cycle after its push; `level` never exceeds 1.
- **Drop counter saturation:** CNT_WIDTH=2, FIFO full, 5 further pushes. Required: `drop_cnt` sequence 1, 2, 3, 3, 3.
- **Reset mid-stream:** `rst_n` low with `level`=3 and `overflow`=1, asynchronously between edges. Required: outputs go to reset values immediately; `warm`=0; warm-up restarts after release.
